mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit quad 2:1 strobed mux. It grants the mux to one requester at a time and drives the mux `select` and `strobe` lines. It waits a programmable settle time, then captures the mux output `Y` into a register. It presents the captured word on a valid/ready output port. It sits between the two 4-bit sources and the downstream consumer, and is the only driver of the mux control pins.

## Interface
- `SETTLE`, default 2: cycles the mux must be enabled before `Y` is sampled. Legal range 1..15, 4-bit counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_a` in 1: requester A wants a transfer. Level signal.
- `req_b` in 1: requester B wants a transfer. Level signal.
- `gnt_a` out 1: A owns the mux. A holds its data stable while this is high.
- `gnt_b` out 1: B owns the mux. B holds its data stable while this is high.
- `select` out 1: mux select. 0 routes A, 1 routes B.
- `strobe` out 1: mux strobe, active-low enable. 1 forces `Y` to 4'h0.
- `mux_y` in 4: mux output `Y`.
- `out_data` out 4: captured word.
- `out_src` out 1: source of `out_data`. 0 is A, 1 is B.
- `out_valid` out 1: `out_data` and `out_src` are valid.
- `out_ready` in 1: consumer accepts the word.

## Operation
- States:
  - IDLE: `strobe`=1, no grant.
  - SETTLE: grant asserted, `strobe`=0, counter running.
  - OUT: word held, `out_valid`=1, `strobe`=1.
- Round-robin pointer `prio` is 0 (A favoured) or 1 (B favoured).
  - Winner with one request: that requester.
  - Winner with both requesting: the side named by `prio`.
  - On every grant, `prio` flips to the loser's side.
- IDLE → SETTLE when `req_a` | `req_b`. Registered in the same edge:
  - `gnt_x`=1 for the winner.
  - `select`=winner.
  - `strobe`=0.
  - counter=`SETTLE`-1.
- SETTLE:
  - Counter decrements each cycle.
  - At count 0, the next edge does all of: `out_data`←`mux_y`, `out_src`←`select`, `out_valid`←1, grant←0, `strobe`←1, state←OUT.
- OUT:
  - Holds `out_data`, `out_src` and `out_valid` until `out_valid` & `out_ready`.
  - On handshake with any request pending: go directly to SETTLE with new arbitration, skipping IDLE. `out_valid` drops in the same edge.
  - On handshake with no request pending: go to IDLE, `out_valid`←0.
- Requests are sampled only in IDLE and at the OUT handshake edge. Changes at other times are ignored.
- A requester whose `req` is still high after its grant falls gets re-arbitrated. Requesters drop `req` on the falling edge of their `gnt`.
- Mutual exclusion: `gnt_a` & `gnt_b` never both 1. `strobe`=0 only while a grant is high.
- `select` holds its last value outside SETTLE.

## Timing
- Reset values, applied immediately on `rst` and independent of `clk`:
  - state=IDLE.
  - `gnt_a`=`gnt_b`=0.
  - `select`=0.
  - `strobe`=1.
  - `out_data`=4'h0.
  - `out_src`=0.
  - `out_valid`=0.
  - `prio`=0.
  - counter=0.
- Reset mid-transfer discards the in-flight word. No `out_valid` pulse occurs.
- Latency, with `req` first high before edge E:
  - grant from E.
  - `out_valid` from E+`SETTLE`.
  - `out_data` equals `mux_y` as sampled at edge E+`SETTLE`.
- `SETTLE`=1: grant lasts exactly one cycle.
- Throughput with `out_ready` tied high and continuous requests: one word per `SETTLE`+1 cycles. Grants alternate A, B, A, ...
- Back-pressure: `out_ready`=0 holds OUT indefinitely. No new grant is issued and `strobe` stays 1.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, then idle with `rst`=0 and no requests → `strobe`=1, both grants 0, `out_valid`=0, `out_data`=0 for 20 cycles.
- Single transfer: `req_a`=1 before edge 1, `SETTLE`=2, `a_data`=4'hA, mux model returns `Y`=A when `select`=0 and `strobe`=0, `out_ready`=1:
  - `gnt_a` high for edges 1–2.
  - `out_valid` high one cycle from edge 3 with `out_data`=4'hA and `out_src`=0.
  - IDLE at edge 4.
- Contention: `req_a`=`req_b`=1 continuously, `out_ready`=1 → grant order A, B, A, B with one word every 3 cycles, and `gnt_a` & `gnt_b` never both 1.
- Back-pressure: word from B (4'h5) captured, `out_ready`=0 for 10 cycles → `out_valid` and `out_data`=4'h5 stable, `strobe`=1, no grant. After `out_ready`=1, handshake completes in 1 cycle.
- Async reset asserted mid-SETTLE, between clock edges → outputs take reset values before the next edge. After release, `req_a` and `req_b` both high → A is granted first (`prio`=0).
- `SETTLE`=1 and `SETTLE`=15 builds → grant widths of 1 and 15 cycles, with capture at edge E+1 and E+15 respectively.

Source files
------------

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-bit strobed 2:1 mux: grants one
// requester, enables the mux for SETTLE cycles, captures Y and offers it on a valid/ready port.
module mux_arbiter #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       select,
    output logic       strobe,
    input  logic [3:0] mux_y,
    output logic [3:0] out_data,
    output logic       out_src,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OUT
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic       prio;
    logic [3:0] cnt;
    logic       any_req;
    logic       winner;

    // winner only feeds registers, so outputs stay free of combinational paths
    always_comb begin
        any_req = req_a | req_b;
        winner  = (req_a && req_b) ? prio : req_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            select    <= 1'b0;
            strobe    <= 1'b1;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_valid <= 1'b0;
            prio      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state  <= S_SETTLE;
                        gnt_a  <= ~winner;
                        gnt_b  <= winner;
                        select <= winner;
                        strobe <= 1'b0;
                        cnt    <= CNT_INIT;
                        prio   <= ~winner;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state     <= S_OUT;
                        out_data  <= mux_y;
                        out_src   <= select;
                        out_valid <= 1'b1;
                        gnt_a     <= 1'b0;
                        gnt_b     <= 1'b0;
                        strobe    <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // a pending request re-arbitrates directly, skipping IDLE
                        if (any_req) begin
                            state  <= S_SETTLE;
                            gnt_a  <= ~winner;
                            gnt_b  <= winner;
                            select <= winner;
                            strobe <= 1'b0;
                            cnt    <= CNT_INIT;
                            prio   <= ~winner;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: vector table, hand-written corner sequences and a
// randomized run against a timestamp-based transaction model.
module tb_mux_arbiter;

    localparam int unsigned S_MAIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, out_ready;
    logic       gnt_a, gnt_b, select, strobe, out_src, out_valid;
    logic [3:0] mux_y, out_data, a_data, b_data;

    logic       r1, r15, zero_b, one_rdy;
    logic       ga1, gb1, sel1, stb1, os1, ov1;
    logic       ga15, gb15, sel15, stb15, os15, ov15;
    logic [3:0] y1, y15, od1, od15, x_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mux_y = strobe ? 4'h0 : (select ? b_data : a_data);
    assign y1    = stb1  ? 4'h0 : (sel1  ? 4'h0 : x_data);
    assign y15   = stb15 ? 4'h0 : (sel15 ? 4'h0 : x_data);

    mux_arbiter #(.SETTLE(S_MAIN)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .select(select), .strobe(strobe), .mux_y(mux_y), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready));

    mux_arbiter #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .req_a(r1), .req_b(zero_b), .gnt_a(ga1), .gnt_b(gb1),
        .select(sel1), .strobe(stb1), .mux_y(y1), .out_data(od1),
        .out_src(os1), .out_valid(ov1), .out_ready(one_rdy));

    mux_arbiter #(.SETTLE(15)) dut15 (
        .clk(clk), .rst(rst), .req_a(r15), .req_b(zero_b), .gnt_a(ga15), .gnt_b(gb15),
        .select(sel15), .strobe(stb15), .mux_y(y15), .out_data(od15),
        .out_src(os15), .out_valid(ov15), .out_ready(one_rdy));

    // {gnt_a, gnt_b, select, strobe, out_valid, out_src, out_data}
    function automatic logic [9:0] pk();
        return {gnt_a, gnt_b, select, strobe, out_valid, out_src, out_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = 0; req_b = 0; out_ready = 0; r1 = 0; r15 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ra, rb, rdy;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic ra, rb, rdy, ga, gb, sel, stb, ov, os,
                                input logic [3:0] od);
        vec_t v;
        v.ra = ra; v.rb = rb; v.rdy = rdy;
        v.exp = {ga, gb, sel, stb, ov, os, od};
        return v;
    endfunction

    vec_t vecs[13];

    // transaction model state
    bit         m_act, m_side, m_prio, m_have, m_src, m_sel;
    logic [3:0] m_data;
    int         m_gstart, t;

    task automatic m_arb(input bit ra, input bit rb);
        bit w;
        if (ra || rb) begin
            w        = (ra && rb) ? m_prio : rb;
            m_prio   = !w;
            m_act    = 1;
            m_side   = w;
            m_sel    = w;
            m_gstart = t;
        end
    endtask

    initial begin
        int gcount, w1, w15, cap1, cap15, got;
        int gedge[4];
        bit gside[4];
        bit prev;
        logic [3:0] d1, d15;

        zero_b = 0; one_rdy = 1; x_data = 4'hC;
        a_data = 4'hA; b_data = 4'h5;
        do_reset();

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle", pk(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
        end

        // vector table (SETTLE=2, A=4'hA, B=4'h5)
        vecs[0]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 4'h0);
        vecs[1]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 4'h0);
        vecs[2]  = mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 4'hA);
        vecs[3]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 4'hA);
        vecs[4]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 4'hA);
        vecs[5]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 4'hA);
        vecs[6]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 1, 4'h5);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 4'h5);
        vecs[8]  = mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 4'h5);
        vecs[9]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 4'h5);
        vecs[10] = mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 4'h5);
        vecs[11] = mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 4'hA);
        vecs[12] = mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 4'hA);
        for (int i = 0; i < 13; i++) begin
            req_a = vecs[i].ra; req_b = vecs[i].rb; out_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i), pk(), vecs[i].exp);
        end

        // contention: grants alternate A,B,A,B every S_MAIN+1 edges
        do_reset();
        req_a = 1; req_b = 1; out_ready = 1;
        gcount = 0; prev = 0;
        for (int e = 1; e <= 14; e++) begin
            step();
            check("excl", {31'd0, gnt_a & gnt_b}, 32'd0);
            if ((gnt_a | gnt_b) && !prev && gcount < 4) begin
                gedge[gcount] = e; gside[gcount] = gnt_b; gcount++;
            end
            prev = gnt_a | gnt_b;
        end
        check("cont_count", gcount, 4);
        for (int i = 0; i < gcount; i++) begin
            check($sformatf("cont_side%0d", i), {31'd0, gside[i]}, i % 2);
            if (i > 0) check($sformatf("cont_gap%0d", i), gedge[i] - gedge[i-1], S_MAIN + 1);
        end

        // back-pressure on a word from B
        do_reset();
        b_data = 4'h5; req_b = 1; out_ready = 0;
        got = 0;
        for (int e = 0; e < 10 && !got; e++) begin
            step();
            if (out_valid) got = 1;
            if (!gnt_b) req_b = 0;
        end
        check("bp_capture", got, 1);
        req_b = 0; req_a = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", pk(), {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5});
        end
        out_ready = 1;
        step();
        check("bp_release", pk(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5});

        // async reset mid-SETTLE, then prio must be back to A
        do_reset();
        req_a = 1; out_ready = 1;
        step();
        check("ar_granted", {31'd0, gnt_a}, 1);
        #3 rst = 1'b1;
        #1 check("ar_async", pk(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
        step();
        step();
        check("ar_no_valid", {31'd0, out_valid}, 0);
        rst = 1'b0; req_a = 1; req_b = 1;
        step();
        check("ar_prio_a", {30'd0, gnt_a, gnt_b}, 2'b10);
        req_a = 0; req_b = 0;

        // SETTLE=1 and SETTLE=15 grant widths and capture edges
        do_reset();
        r1 = 1; r15 = 1;
        w1 = 0; w15 = 0; cap1 = -1; cap15 = -1; d1 = 0; d15 = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (ga1) w1++;
            if (ga15) w15++;
            if (ov1 && cap1 < 0) begin cap1 = e; d1 = od1; end
            if (ov15 && cap15 < 0) begin cap15 = e; d15 = od15; end
            if (w1 > 0 && !ga1) r1 = 0;
            if (w15 > 0 && !ga15) r15 = 0;
        end
        check("s1_width", w1, 1);
        check("s15_width", w15, 15);
        check("s1_cap", cap1, 2);
        check("s15_cap", cap15, 16);
        check("s1_data", {28'd0, d1}, {28'd0, 4'hC});
        check("s15_data", {28'd0, d15}, {28'd0, 4'hC});

        // randomized run against the transaction model
        do_reset();
        m_act = 0; m_side = 0; m_prio = 0; m_have = 0; m_src = 0; m_sel = 0;
        m_data = 0; m_gstart = 0; t = 0;
        for (int i = 0; i < 800; i++) begin
            req_a = 1'($urandom);
            req_b = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            if (!gnt_a) a_data = 4'($urandom);
            if (!gnt_b) b_data = 4'($urandom);
            @(posedge clk);
            t++;
            if (m_act) begin
                if (t - m_gstart == int'(S_MAIN)) begin
                    m_act = 0; m_have = 1; m_src = m_side;
                    m_data = m_side ? b_data : a_data;
                end
            end else if (m_have) begin
                if (out_ready) begin
                    m_have = 0;
                    m_arb(req_a, req_b);
                end
            end else begin
                m_arb(req_a, req_b);
            end
            #1;
            check("rand", pk(), {m_act && !m_side, m_act && m_side, m_sel, !m_act,
                                 m_have, m_src, m_data});
            check("rand_excl", {31'd0, (gnt_a & gnt_b) | (!strobe & !(gnt_a | gnt_b))}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
